// File: rtl/core_dma_pkg.sv
// Shared types and constants for the OAM sprite-memory DMA controller.
// Used by core_oam_dma; the ALIGN state only becomes reachable when OAM_DMA_ALIGN_EN is defined.
package core_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_type;

    localparam logic [15:0] DEF_TRIGGER_ADDR = 16'h4014;
    localparam logic [15:0] DEF_DEST_ADDR    = 16'h2004;
    localparam int          XFER_LEN         = 256;
    localparam logic [7:0]  LAST_IDX         = 8'(XFER_LEN - 1);

endpackage

// File: rtl/core_oam_dma.sv
// OAM DMA controller and bus arbiter: stalls the 6502 core and copies one 256-byte page to the sprite port.
// Optional feature: define OAM_DMA_ALIGN_EN to keep every DMA read on a "get" (parity 0) CPU cycle.
//
// state | meaning
// IDLE  | bus passes through from the core, watching for a write to the trigger address
// HALT  | core stalled; bus performs a dummy read of the frozen core address
// ALIGN | one extra dummy read so the first READ lands on a get cycle
// READ  | read byte {page, idx} from memory
// WRITE | write the latched byte to the destination port
module core_oam_dma
    import core_dma_pkg::*;
#(
    parameter logic [15:0] P_TRIGGER_ADDR = DEF_TRIGGER_ADDR,
    parameter logic [15:0] P_DEST_ADDR    = DEF_DEST_ADDR
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_cycle,
    input  logic [15:0] I_cpu_addr,
    input  logic [7:0]  I_cpu_wr_data,
    input  logic        I_cpu_rdwr,
    input  logic [7:0]  I_rd_data,
    output logic [15:0] O_addr,
    output logic [7:0]  O_wr_data,
    output logic        O_rdwr,
    output logic        O_ready,
    output logic        O_busy
);

    dma_state_type state_q, state_d;
    logic [7:0]    page_q, page_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;

`ifdef OAM_DMA_ALIGN_EN
    logic          parity_q, parity_d;

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_d = parity_q ^ I_cycle;
`endif

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (I_cycle) begin
            case (state_q)
                ST_IDLE: begin
                    if (!I_cpu_rdwr && (I_cpu_addr == P_TRIGGER_ADDR)) begin
                        page_d  = I_cpu_wr_data;
                        idx_d   = 8'h00;
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    // HALT on a get cycle means the following cycle is a put: burn it in ALIGN.
                    state_d = parity_q ? ST_READ : ST_ALIGN;
`else
                    state_d = ST_READ;
`endif
                end
                ST_ALIGN: begin
                    state_d = ST_READ;
                end
                ST_READ: begin
                    data_d  = I_rd_data;
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_READ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Bus mux is purely combinational so pass-through adds no latency.
    always_comb begin
        O_addr    = I_cpu_addr;
        O_wr_data = I_cpu_wr_data;
        O_rdwr    = I_cpu_rdwr;
        O_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                O_ready = 1'b1;
            end
            ST_HALT, ST_ALIGN: begin
                O_rdwr = 1'b1;
            end
            ST_READ: begin
                O_addr = {page_q, idx_q};
                O_rdwr = 1'b1;
            end
            ST_WRITE: begin
                O_addr    = P_DEST_ADDR;
                O_wr_data = data_q;
                O_rdwr    = 1'b0;
            end
            default: begin
                O_ready = 1'b0;
            end
        endcase
    end

    assign O_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_core_oam_dma.sv
// Self-checking bench for core_oam_dma: pass-through vector table plus randomized page copies vs. a memory model.
// Expectations honour OAM_DMA_ALIGN_EN when it is defined for the build.
module tb_core_oam_dma;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] DEST = 16'h2004;

    logic        I_clock = 1'b0;
    logic        I_reset = 1'b0;
    logic        I_cycle = 1'b0;
    logic [15:0] I_cpu_addr = 16'h0000;
    logic [7:0]  I_cpu_wr_data = 8'h00;
    logic        I_cpu_rdwr = 1'b1;
    logic [7:0]  I_rd_data;
    logic [15:0] O_addr;
    logic [7:0]  O_wr_data;
    logic        O_rdwr;
    logic        O_ready;
    logic        O_busy;

    core_oam_dma dut (
        .I_clock      (I_clock),
        .I_reset      (I_reset),
        .I_cycle      (I_cycle),
        .I_cpu_addr   (I_cpu_addr),
        .I_cpu_wr_data(I_cpu_wr_data),
        .I_cpu_rdwr   (I_cpu_rdwr),
        .I_rd_data    (I_rd_data),
        .O_addr       (O_addr),
        .O_wr_data    (O_wr_data),
        .O_rdwr       (O_rdwr),
        .O_ready      (O_ready),
        .O_busy       (O_busy)
    );

    always #5 I_clock = ~I_clock;

    logic [7:0] mem [0:65535];
    assign I_rd_data = mem[O_addr];

    int ncmp = 0;
    int nmis = 0;

    // Bus observer: every strobe is one committed bus cycle.
    bit          bpar = 1'b0;
    int          stall = 0;
    bit          zero_hit = 1'b0;
    logic [7:0]  wq[$];
    logic [15:0] rq[$];
    bit          rpq[$];

    always @(negedge I_clock) begin
        if (!I_reset) begin
            bpar = 1'b0;
        end else if (I_cycle) begin
            if (!O_ready) stall++;
            if (O_busy && !O_rdwr && O_addr == DEST) wq.push_back(O_wr_data);
            if (O_busy && O_rdwr && O_addr != I_cpu_addr) begin
                rq.push_back(O_addr);
                rpq.push_back(bpar);
            end
            if (O_busy && O_addr == 16'h0000) zero_hit = 1'b1;
            bpar = ~bpar;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
        I_cpu_addr    = a;
        I_cpu_wr_data = d;
        I_cpu_rdwr    = rw;
    endtask

    // Ends one CPU cycle after 0-2 idle clocks; returns #1 after the strobed edge.
    task automatic strobe();
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(posedge I_clock);
            #1;
        end
        I_cycle = 1'b1;
        @(posedge I_clock);
        #1;
        I_cycle = 1'b0;
    endtask

    task automatic run_dma(input logic [7:0] page, input bit odd, input int abort_at);
        logic [7:0] expq[$];
        int         budget;
        bit         tpar;
        int         exp_stall;
        int         n;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = (page == 8'h02) ? (8'(i) ^ 8'h5A) : 8'($urandom);
            mem[{page, 8'(i)}] = v;
            expq.push_back(v);
        end
        wq.delete();
        rq.delete();
        rpq.delete();
        zero_hit = 1'b0;
        drive(16'h1000, 8'h00, 1'b1);
        if (bpar != odd) strobe();
        tpar  = bpar;
        stall = 0;
        drive(TRIG, page, 1'b0);
        strobe();
        chk("halt_ready", 32'(O_ready), 32'd0);
        chk("halt_busy", 32'(O_busy), 32'd1);
        drive(TRIG, 8'h00, 1'b1);
        budget = 0;
        while (O_busy && budget < 600) begin
            strobe();
            budget++;
            if (abort_at >= 0 && wq.size() == abort_at) break;
        end
        if (abort_at >= 0) begin
            I_reset = 1'b0;
            #2;
            chk("abort_busy", 32'(O_busy), 32'd0);
            chk("abort_ready", 32'(O_ready), 32'd1);
            chk("abort_addr", 32'(O_addr), 32'(TRIG));
            #3;
            I_reset = 1'b1;
            for (int k = 0; k < 20; k++) strobe();
            chk("abort_writes", 32'(wq.size()), 32'(abort_at));
            chk("abort_idle", 32'(O_busy), 32'd0);
            return;
        end
        chk("done_in_budget", 32'(O_busy), 32'd0);
        chk("ready_after", 32'(O_ready), 32'd1);
`ifdef OAM_DMA_ALIGN_EN
        exp_stall = 513 + int'(tpar);
`else
        exp_stall = 513;
`endif
        chk("stall_cycles", 32'(stall), 32'(exp_stall));
        chk("write_count", 32'(wq.size()), 32'd256);
        chk("read_count", 32'(rq.size()), 32'd256);
        n = (wq.size() < 256) ? wq.size() : 256;
        for (int i = 0; i < n; i++) chk("write_data", 32'(wq[i]), 32'(expq[i]));
        n = (rq.size() < 256) ? rq.size() : 256;
        for (int i = 0; i < n; i++) chk("read_addr", 32'(rq[i]), 32'({page, 8'(i)}));
`ifdef OAM_DMA_ALIGN_EN
        for (int i = 0; i < n; i++) chk("read_parity", 32'(rpq[i]), 32'd0);
`endif
        if (page == 8'hFF) begin
            chk("last_read_ffff", (rq.size() > 0) ? 32'(rq[rq.size()-1]) : 32'hDEAD, 32'h0000FFFF);
            chk("no_zero_access", 32'(zero_hit), 32'd0);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        rdwr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] rp;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        vecs[0] = '{16'h1234, 8'h77, 1'b1};
        vecs[1] = '{16'h4015, 8'hAB, 1'b0};
        vecs[2] = '{16'h4014, 8'h02, 1'b1};
        vecs[3] = '{16'h4013, 8'h11, 1'b0};
        vecs[4] = '{16'h0014, 8'h40, 1'b0};
        vecs[5] = '{16'hFFFF, 8'hC3, 1'b1};
        vecs[6] = '{16'h0000, 8'h3C, 1'b0};

        drive(16'h1234, 8'h77, 1'b1);
        repeat (3) @(posedge I_clock);
        #1;
        chk("rst_ready", 32'(O_ready), 32'd1);
        chk("rst_busy", 32'(O_busy), 32'd0);
        chk("rst_addr", 32'(O_addr), 32'h1234);
        chk("rst_rdwr", 32'(O_rdwr), 32'd1);
        chk("rst_wdata", 32'(O_wr_data), 32'h77);
        I_reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].rdwr);
            #1;
            chk("pt_addr", 32'(O_addr), 32'(vecs[i].addr));
            chk("pt_wdata", 32'(O_wr_data), 32'(vecs[i].wdata));
            chk("pt_rdwr", 32'(O_rdwr), 32'(vecs[i].rdwr));
            chk("pt_ready", 32'(O_ready), 32'd1);
            strobe();
            chk("pt_busy_after", 32'(O_busy), 32'd0);
        end

        run_dma(8'h02, 1'b0, -1);
        run_dma(8'h02, 1'b1, -1);
        run_dma(8'hFF, 1'($urandom), -1);
        run_dma(8'h37, 1'b0, 100);
        for (int t = 0; t < 3; t++) begin
            rp = 8'($urandom);
            if (rp == 8'h40) rp = 8'h41;
            run_dma(rp, 1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule

// File: doc/core_oam_dma.md
# core_oam_dma

Sprite-memory DMA controller and bus arbiter between the 6502 core and system memory. When the CPU writes a page number to the trigger address, the block stalls the core through its ready input and takes ownership of the address/data bus. It then copies 256 bytes from `$PP00-$PPFF` to the sprite data port and returns the bus to the core. All sequencing advances on the CPU-cycle strobe, so DMA cycles line up exactly with core bus cycles.

## Interface
- `P_TRIGGER_ADDR`, default `16'h4014`: CPU write address that starts a transfer; the written byte is the source page.
- `P_DEST_ADDR`, default `16'h2004`: destination address written once per byte.
- `I_clock`  in  1: system clock, the same clock as the core.
- `I_reset`  in  1: reset, asynchronous, active-low.
- `I_cycle`  in  1: one-clock strobe marking the end of each CPU bus cycle (the core's phy2 falling-edge strobe).
- `I_cpu_addr`  in  16: core address.
- `I_cpu_wr_data`  in  8: core write data.
- `I_cpu_rdwr`  in  1: core direction; 1 = read, 0 = write.
- `I_rd_data`  in  8: memory read data; also forwarded to the core unchanged by the top level.
- `O_addr`  out  16: arbitrated memory address.
- `O_wr_data`  out  8: arbitrated write data.
- `O_rdwr`  out  1: arbitrated direction; 1 = read.
- `O_ready`  out  1: drives the core's `I_ready`; 0 stalls the core.
- `O_busy`  out  1: 1 whenever the state is not IDLE.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE. State changes only on a clock where `I_cycle=1`.
- Parity bit:
  - Toggles on every `I_cycle`.
  - 0 marks a "get" cycle, 1 marks a "put" cycle.
- IDLE:
  - Bus is a pass-through: `O_addr`/`O_wr_data`/`O_rdwr` equal the CPU inputs.
  - `O_ready=1`.
  - Trigger condition: `I_cycle=1`, `I_cpu_rdwr=0` and `I_cpu_addr==P_TRIGGER_ADDR`.
  - On trigger: latch `page<=I_cpu_wr_data`, clear `idx<=0`, go to HALT. The CPU write itself also reaches memory.
- HALT:
  - One cycle; `O_ready=0`.
  - Bus drives a read of `I_cpu_addr`, which is harmless because the core is frozen.
  - Exit: ALIGN if the next cycle is a put cycle (see Configuration), otherwise READ.
- ALIGN:
  - One cycle; same bus drive as HALT.
  - Exit: always READ.
- READ:
  - Drives `O_addr={page,idx}` with `O_rdwr=1`.
  - On `I_cycle`, latch `data<=I_rd_data`, then go to WRITE.
- WRITE:
  - Drives `O_addr=P_DEST_ADDR`, `O_wr_data=data`, `O_rdwr=0`.
  - On `I_cycle`: if `idx==8'hFF`, go to IDLE; otherwise `idx<=idx+1` (8-bit) and go to READ.
- `O_ready` is 0 in every state except IDLE.
- Triggers are not detected outside IDLE.
- Page `$FF`: addresses `$FF00-$FFFF`; `idx` does not carry into `page`.

## Timing
- Reset values: IDLE, parity 0, page 0, idx 0, data 0, `O_ready=1`, `O_busy=0`.
  - Bus outputs pass through the CPU inputs in reset and in IDLE.
- Bus outputs and `O_ready` are combinational from registered state plus the CPU inputs. No added latency in pass-through.
- Trigger write at cycle n:
  - HALT occupies cycle n+1, and `O_ready` goes low after the trigger strobe.
  - First READ is at cycle n+2, or n+3 when ALIGN is inserted.
- Transfer length, counting HALT through the last WRITE: 513 cycles, or 514 with ALIGN.
- `O_ready` returns to 1 in the cycle after the last WRITE.
- Reset asserted mid-transfer: the block returns to IDLE immediately (asynchronous), the transfer is abandoned, and no further DMA write is issued.
- `I_cycle` low: all state holds, and outputs stay stable for the whole CPU cycle.

## Configuration
- `OAM_DMA_ALIGN_EN` defined:
  - ALIGN is inserted when the parity after HALT would make the first READ fall on a put cycle.
  - Every READ is then on a get cycle; totals are 513 or 514.
- Not defined:
  - ALIGN state and parity bit are compiled out; HALT always goes to READ.
  - Total is always 513.

## Structure
- Shared package `core_dma_pkg`:
  - State enum type `dma_state_type`.
  - Default trigger and destination address constants.
  - Transfer length constant `256`.
- No sub-module: the counter, latches and bus mux sit inline in `core_oam_dma`.
- The top level instantiates it between `core` and memory.

## Test plan
- Reset: hold `I_reset=0`, drive CPU address `$1234` as a read. Expect `O_ready=1`, `O_busy=0`, `O_addr=$1234`, `O_rdwr=1`.
- Basic copy: CPU writes `$02` to `$4014`, memory `$0200+i` = `i^$5A`.
  - Expect exactly 256 writes to `$2004` with data `i^$5A`, in order.
  - Expect `O_ready` low for 513 or 514 cycles, matching parity.
- Alignment (`OAM_DMA_ALIGN_EN`): trigger once on an even cycle and once on an odd cycle. Expect 513 and 514 stall cycles respectively, and every READ on parity 0.
- Page `$FF`: trigger with `$FF`. Expect the last read at `$FFFF` and no access to `$0000`.
- Mid-transfer reset: pulse `I_reset` low after the 100th write. Expect IDLE, `O_ready=1` and no further writes to `$2004`.
- Non-trigger: CPU reads `$4014` and writes `$4015`. Expect no state change and `O_busy=0`.
